// File: rtl/da_accumulator_if.sv
// Slice-rate bundle between the LUT bank and the DA accumulator:
// eight partial products with an enable going in, the finished word and its valid pulse coming out.
interface da_accumulator_if;
   logic               en;
   logic signed [15:0] LUT0_out;
   logic signed [15:0] LUT1_out;
   logic signed [15:0] LUT2_out;
   logic signed [15:0] LUT3_out;
   logic signed [15:0] LUT4_out;
   logic signed [15:0] LUT5_out;
   logic signed [15:0] LUT6_out;
   logic signed [15:0] LUT7_out;
   logic signed [31:0] sum;
   logic               sum_valid;

   modport master (
      output en, LUT0_out, LUT1_out, LUT2_out, LUT3_out,
             LUT4_out, LUT5_out, LUT6_out, LUT7_out,
      input  sum, sum_valid
   );

   modport slave (
      input  en, LUT0_out, LUT1_out, LUT2_out, LUT3_out,
             LUT4_out, LUT5_out, LUT6_out, LUT7_out,
      output sum, sum_valid
   );
endinterface

// File: rtl/da_accumulator.sv
// Bit-serial DA accumulation stage: adds the eight LUT partial products of a slice and
// shift-accumulates slices MSB-first, registering a 32-bit result after NBITS slices.
module da_accumulator #(
   parameter int NBITS = 16,
   parameter int CW    = 5
) (
   input  logic              clk3,
   input  logic              reset,
   da_accumulator_if.slave   bus
);

   logic [CW-1:0]      count_q, count_d;
   logic signed [31:0] acc_q, acc_d;
   logic signed [31:0] sum_q, sum_d;
   logic               sum_valid_q, sum_valid_d;

   logic signed [31:0] lut_ext [8];
   logic signed [31:0] pair_sum [4];
   logic signed [31:0] quad_sum [2];
   logic signed [31:0] lut_sum;
   logic               first_slice;
   logic               count_reach;

   // Balanced tree keeps the carry chain depth at three 32-bit adds.
   assign lut_ext[0] = 32'(bus.LUT0_out);
   assign lut_ext[1] = 32'(bus.LUT1_out);
   assign lut_ext[2] = 32'(bus.LUT2_out);
   assign lut_ext[3] = 32'(bus.LUT3_out);
   assign lut_ext[4] = 32'(bus.LUT4_out);
   assign lut_ext[5] = 32'(bus.LUT5_out);
   assign lut_ext[6] = 32'(bus.LUT6_out);
   assign lut_ext[7] = 32'(bus.LUT7_out);

   assign pair_sum[0] = lut_ext[0] + lut_ext[1];
   assign pair_sum[1] = lut_ext[2] + lut_ext[3];
   assign pair_sum[2] = lut_ext[4] + lut_ext[5];
   assign pair_sum[3] = lut_ext[6] + lut_ext[7];
   assign quad_sum[0] = pair_sum[0] + pair_sum[1];
   assign quad_sum[1] = pair_sum[2] + pair_sum[3];
   assign lut_sum     = quad_sum[0] + quad_sum[1];

   assign first_slice = (count_q == '0);
   assign count_reach = bus.en && (count_q == CW'(NBITS - 1));

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      count_d     = count_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      sum_valid_d = 1'b0;

      if (bus.en) begin
         count_d = count_reach ? '0 : count_q + CW'(1);
         // Loading on slice 0 drops the previous word without a separate clear cycle.
         acc_d   = first_slice ? lut_sum : {acc_q[30:0], 1'b0} + lut_sum;
         if (count_reach) begin
            sum_d       = acc_d;
            sum_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk3 or negedge reset) begin
      if (!reset) begin
         count_q     <= '0;
         acc_q       <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         count_q     <= count_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         sum_valid_q <= sum_valid_d;
      end
   end

   assign bus.sum       = sum_q;
   assign bus.sum_valid = sum_valid_q;

endmodule

// File: tb/tb_da_accumulator.sv
// Directed bench for da_accumulator: reset, constant-slice words, single-slice weighting,
// negative products, mid-word enable pause and mid-word reset.
module tb_da_accumulator;

   logic clk3  = 1'b0;
   logic reset = 1'b0;

   da_accumulator_if bus ();

   da_accumulator #(.NBITS(16), .CW(5)) dut (
      .clk3  (clk3),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk3 = ~clk3;

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_luts(input logic [15:0] l0, input logic [15:0] rest);
      bus.LUT0_out = l0;
      bus.LUT1_out = rest;
      bus.LUT2_out = rest;
      bus.LUT3_out = rest;
      bus.LUT4_out = rest;
      bus.LUT5_out = rest;
      bus.LUT6_out = rest;
      bus.LUT7_out = rest;
   endtask

   // Apply one slice, take one rising edge, return 1 time unit after it.
   task automatic slice(input logic e, input logic [15:0] l0, input logic [15:0] rest);
      bus.en = e;
      set_luts(l0, rest);
      @(posedge clk3);
      #1;
   endtask

   initial begin
      bus.en = 1'b0;
      set_luts(16'h0000, 16'h0000);

      // 1: reset held with enable and random inputs
      for (int i = 0; i < 5; i++) begin
         bus.en       = 1'b1;
         bus.LUT0_out = 16'($urandom);
         bus.LUT1_out = 16'($urandom);
         bus.LUT2_out = 16'($urandom);
         bus.LUT3_out = 16'($urandom);
         bus.LUT4_out = 16'($urandom);
         bus.LUT5_out = 16'($urandom);
         bus.LUT6_out = 16'($urandom);
         bus.LUT7_out = 16'($urandom);
         @(posedge clk3);
         #1;
         check("rst_sum", bus.sum, 32'h0);
         check("rst_valid", 32'(bus.sum_valid), 32'h0);
      end
      bus.en = 1'b0;
      @(negedge clk3);
      reset = 1'b1;
      #1;

      // 2: sixteen slices of all 0x0001, first enabled slice is slice 0
      for (int k = 0; k < 16; k++) begin
         slice(1'b1, 16'h0001, 16'h0001);
         if (k == 14) check("ones_valid_early", 32'(bus.sum_valid), 32'h0);
      end
      check("ones_sum", bus.sum, 32'h0007FFF8);
      check("ones_valid", 32'(bus.sum_valid), 32'h1);

      // 3: back-to-back word, 3 on LUT0 in slice 0 only
      slice(1'b1, 16'h0003, 16'h0000);
      check("single_valid_drop", 32'(bus.sum_valid), 32'h0);
      check("single_sum_hold", bus.sum, 32'h0007FFF8);
      for (int k = 1; k < 16; k++) slice(1'b1, 16'h0000, 16'h0000);
      check("single_sum", bus.sum, 32'h00018000);
      check("single_valid", 32'(bus.sum_valid), 32'h1);
      for (int k = 0; k < 16; k++) slice(1'b1, 16'h0000, 16'h0000);
      check("zero_sum", bus.sum, 32'h0);
      check("zero_valid", 32'(bus.sum_valid), 32'h1);

      // 4: all products -1
      for (int k = 0; k < 16; k++) slice(1'b1, 16'hFFFF, 16'hFFFF);
      check("neg_sum", bus.sum, 32'hFFF80008);
      check("neg_valid", 32'(bus.sum_valid), 32'h1);

      // 5: pause three cycles after slice 7
      for (int k = 0; k < 8; k++) slice(1'b1, 16'h0001, 16'h0001);
      for (int k = 0; k < 3; k++) begin
         slice(1'b0, 16'h7777, 16'h1234);
         check("pause_valid", 32'(bus.sum_valid), 32'h0);
         check("pause_sum_hold", bus.sum, 32'hFFF80008);
      end
      for (int k = 8; k < 16; k++) begin
         slice(1'b1, 16'h0001, 16'h0001);
         if (k == 14) check("pause_valid_early", 32'(bus.sum_valid), 32'h0);
      end
      check("pause_sum", bus.sum, 32'h0007FFF8);
      check("pause_valid_pulse", 32'(bus.sum_valid), 32'h1);
      slice(1'b0, 16'h0000, 16'h0000);
      check("pause_valid_one_cycle", 32'(bus.sum_valid), 32'h0);

      // 6: reset during slice 9, then a full word of 0x0002
      for (int k = 0; k < 9; k++) slice(1'b1, 16'h0005, 16'h0005);
      bus.en = 1'b1;
      @(negedge clk3);
      reset = 1'b0;
      #1;
      check("midrst_sum_async", bus.sum, 32'h0);
      check("midrst_valid_async", 32'(bus.sum_valid), 32'h0);
      bus.en = 1'b0;
      @(negedge clk3);
      reset = 1'b1;
      #1;
      for (int k = 0; k < 16; k++) begin
         slice(1'b1, 16'h0002, 16'h0002);
         if (k == 14) check("midrst_valid_early", 32'(bus.sum_valid), 32'h0);
      end
      check("midrst_sum", bus.sum, 32'h000FFFF0);
      check("midrst_valid", 32'(bus.sum_valid), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
